// File: rtl/clock_monitor_pkg.sv
// Shared types and widths for the clock_monitor block.
package clock_monitor_pkg;

  localparam int CNT_W = 28;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Optional two-flop synchronizer, history flop and registered rise/fall strobes.
// Synchronizer present only when CLOCK_MONITOR_SYNC_EN is defined.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic slow_clk,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic edge_det
);

  logic sync;
  logic hist;
  logic rise;
  logic fall;

`ifdef CLOCK_MONITOR_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], slow_clk};
    end
  end

  assign sync = sync_ff[1];
`else
  // slow_clk must already be a register in the clock_in domain here.
  assign sync = slow_clk;
`endif

  assign rise     = sync & ~hist;
  assign fall     = ~sync & hist;
  assign edge_det = rise | fall;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hist       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      hist       <= sync;
      rise_pulse <= rise;
      fall_pulse <= fall;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// Slow-clock monitor: edge strobes, half-period measurement, lock/loss tracking.
// Build with CLOCK_MONITOR_SYNC_EN for an asynchronous slow_clk.
//   state   | meaning
//   IDLE    | waiting for the first edge, nothing measured yet
//   ACQUIRE | measuring, counting consecutive in-tolerance half-periods
//   LOCKED  | stable; an out-of-tolerance half-period counts an error
//   LOST    | no edge for TIMEOUT cycles; next edge restarts acquisition
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter logic [CNT_W-1:0] EXPECTED_HALF = 28'd5,
  parameter logic [CNT_W-1:0] TOLERANCE     = 28'd1,
  parameter int               LOCK_COUNT    = 4,
  parameter logic [CNT_W-1:0] TIMEOUT       = 28'd20
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [ERR_W-1:0] error_count
);

  // Bounds kept one bit wider so EXPECTED_HALF+TOLERANCE cannot wrap.
  localparam logic [CNT_W:0]   TOL_HI = {1'b0, EXPECTED_HALF} + {1'b0, TOLERANCE};
  localparam logic [CNT_W-1:0] TOL_LO = (EXPECTED_HALF > TOLERANCE) ?
                                        (EXPECTED_HALF - TOLERANCE) : '0;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1);
  localparam logic [3:0]       LOCK_RUN     = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       run_q, run_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             edge_det;
  logic [CNT_W-1:0] meas;
  logic             in_tol;
  logic             timeout_hit;
  logic             take_meas;

  sync_edge_detect u_sync_edge_detect (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clk   (slow_clk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_det   (edge_det)
  );

  assign meas        = sat_inc_cnt(cnt_q);
  assign in_tol      = (meas >= TOL_LO) && ({1'b0, meas} <= TOL_HI);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    err_d     = err_q;
    take_meas = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = ACQUIRE;
          run_d   = 4'd0;
        end
      end
      ACQUIRE: begin
        if (edge_det) begin
          take_meas = 1'b1;
          if (in_tol) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 >= LOCK_RUN) begin
              state_d = LOCKED;
            end
          end else begin
            run_d = 4'd0;
          end
        end else if (timeout_hit) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          take_meas = 1'b1;
          if (!in_tol) begin
            err_d   = (&err_q) ? err_q : err_q + ERR_W'(1);
            run_d   = 4'd0;
            state_d = ACQUIRE;
          end
        end else if (timeout_hit) begin
          state_d = LOST;
        end
      end
      LOST: begin
        if (edge_det) begin
          state_d = ACQUIRE;
          run_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_q        <= 4'd0;
      err_q        <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= edge_det ? '0 : sat_inc_cnt(cnt_q);
      run_q        <= run_d;
      err_q        <= err_d;
      period_valid <= take_meas;
      if (take_meas) begin
        half_period <= meas;
      end
    end
  end

  assign locked      = (state_q == LOCKED);
  assign lost        = (state_q == LOST);
  assign error_count = err_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed self-checking bench for clock_monitor (either build of CLOCK_MONITOR_SYNC_EN).
module tb_clock_monitor;

`ifdef CLOCK_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clock_in;
  logic        reset_n;
  logic        slow_clk;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [27:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        lost;
  logic [7:0]  error_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int          obs_pv;
  logic [27:0] obs_m;
  int          obs_rise;
  int          obs_fall;
  int          obs_pos;
  logic        obs_lock_pv;
  int          obs_lost_idx;
  int          obs_both;

  clock_monitor dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .slow_clk     (slow_clk),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost),
    .error_count  (error_count)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Toggle slow_clk, then run h cycles recording what the DUT does.
  task automatic do_half(input int h);
    slow_clk     = ~slow_clk;
    obs_pv       = 0;
    obs_m        = '0;
    obs_rise     = 0;
    obs_fall     = 0;
    obs_pos      = 0;
    obs_lock_pv  = 1'b0;
    obs_lost_idx = 0;
    obs_both     = 0;
    for (int i = 1; i <= h; i++) begin
      tick();
      if (period_valid) begin
        obs_pv++;
        obs_m       = half_period;
        obs_lock_pv = locked;
      end
      if (rise_pulse) obs_rise++;
      if (fall_pulse) obs_fall++;
      if (rise_pulse && fall_pulse) obs_both++;
      if ((rise_pulse || fall_pulse) && obs_pos == 0) obs_pos = i;
      if (lost && obs_lost_idx == 0) obs_lost_idx = i;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    slow_clk = 1'b0;
    #2;
    n_cmp++;
    if ({rise_pulse, fall_pulse, half_period, period_valid, locked, lost, error_count} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rise_pulse, fall_pulse, half_period, period_valid, locked, lost, error_count});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    n_cmp++;
    if ({lost, locked, period_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_no_timeout: lost/locked/pv got %b expected 000", {lost, locked, period_valid});
    end
  endtask

  task automatic test_lock();
    do_half(5);
    n_cmp++;
    if (obs_pv !== 0) begin
      n_fail++; $display("FAIL first_edge_no_meas: pv count %0d expected 0", obs_pv);
    end
    n_cmp++;
    if (obs_rise !== 1 || obs_fall !== 0) begin
      n_fail++; $display("FAIL first_rise: rise %0d fall %0d expected 1 0", obs_rise, obs_fall);
    end
    n_cmp++;
    if (obs_pos !== LAT) begin
      n_fail++; $display("FAIL pulse_latency: got %0d expected %0d", obs_pos, LAT);
    end
    for (int k = 2; k <= 5; k++) begin
      do_half(5);
      n_cmp++;
      if (obs_pv !== 1 || obs_m !== 28'd5) begin
        n_fail++; $display("FAIL meas_5 half %0d: pv %0d m %0d expected 1 5", k, obs_pv, obs_m);
      end
      n_cmp++;
      if (((k % 2) == 0) ? (obs_fall !== 1 || obs_rise !== 0) : (obs_rise !== 1 || obs_fall !== 0)) begin
        n_fail++; $display("FAIL alternate half %0d: rise %0d fall %0d", k, obs_rise, obs_fall);
      end
      n_cmp++;
      if (obs_pos !== LAT) begin
        n_fail++; $display("FAIL pulse_pos half %0d: got %0d expected %0d", k, obs_pos, LAT);
      end
      n_cmp++;
      if (locked !== (k == 5) || obs_lock_pv !== (k == 5)) begin
        n_fail++; $display("FAIL lock_progress half %0d: locked %b at_pv %b expected %b", k, locked, obs_lock_pv, k == 5);
      end
    end
  endtask

  task automatic test_lost();
    do_half(30);
    n_cmp++;
    if (obs_pv !== 1 || obs_m !== 28'd5 || obs_lock_pv !== 1'b1) begin
      n_fail++; $display("FAIL pre_loss_meas: pv %0d m %0d lock %b expected 1 5 1", obs_pv, obs_m, obs_lock_pv);
    end
    n_cmp++;
    if (obs_lost_idx !== LAT + 20) begin
      n_fail++; $display("FAIL lost_timing: got %0d expected %0d", obs_lost_idx, LAT + 20);
    end
    n_cmp++;
    if (lost !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL lost_state: lost %b locked %b expected 1 0", lost, locked);
    end
    do_half(5);
    n_cmp++;
    if (obs_pv !== 0 || lost !== 1'b0 || obs_rise !== 1) begin
      n_fail++; $display("FAIL resume_edge: pv %0d lost %b rise %0d expected 0 0 1", obs_pv, lost, obs_rise);
    end
    for (int k = 1; k <= 4; k++) begin
      do_half(5);
      n_cmp++;
      if (obs_m !== 28'd5 || locked !== (k == 4)) begin
        n_fail++; $display("FAIL relock %0d: m %0d locked %b expected 5 %b", k, obs_m, locked, k == 4);
      end
    end
  endtask

  task automatic test_error();
    do_half(8);
    n_cmp++;
    if (obs_m !== 28'd5 || locked !== 1'b1 || error_count !== 8'd0) begin
      n_fail++; $display("FAIL before_error: m %0d locked %b err %0d expected 5 1 0", obs_m, locked, error_count);
    end
    do_half(5);
    n_cmp++;
    if (obs_pv !== 1 || obs_m !== 28'd8) begin
      n_fail++; $display("FAIL long_meas: pv %0d m %0d expected 1 8", obs_pv, obs_m);
    end
    n_cmp++;
    if (error_count !== 8'd1 || locked !== 1'b0 || obs_lock_pv !== 1'b0) begin
      n_fail++; $display("FAIL error_event: err %0d locked %b at_pv %b expected 1 0 0", error_count, locked, obs_lock_pv);
    end
  endtask

  task automatic test_timeout_edge();
    do_half(20);
    n_cmp++;
    if (obs_m !== 28'd5 || obs_lost_idx !== 0) begin
      n_fail++; $display("FAIL edge_at_timeout_wait: m %0d lost_idx %0d expected 5 0", obs_m, obs_lost_idx);
    end
    do_half(5);
    n_cmp++;
    if (obs_pv !== 1 || obs_m !== 28'd20 || obs_lost_idx !== 0 || lost !== 1'b0) begin
      n_fail++; $display("FAIL edge_at_timeout: pv %0d m %0d lost_idx %0d lost %b expected 1 20 0 0",
                         obs_pv, obs_m, obs_lost_idx, lost);
    end
    n_cmp++;
    if (error_count !== 8'd1) begin
      n_fail++; $display("FAIL acquire_no_error: err %0d expected 1", error_count);
    end
    for (int k = 1; k <= 4; k++) begin
      do_half(5);
      n_cmp++;
      if (locked !== (k == 4)) begin
        n_fail++; $display("FAIL run_cleared %0d: locked %b expected %b", k, locked, k == 4);
      end
    end
  endtask

  task automatic test_saturate();
    for (int it = 0; it < 300; it++) begin
      do_half(8);
      do_half(5);
      repeat (4) do_half(5);
      if (it == 252) begin
        n_cmp++;
        if (error_count !== 8'd254) begin
          n_fail++; $display("FAIL err_count_254: got %0d expected 254", error_count);
        end
      end
    end
    n_cmp++;
    if (error_count !== 8'd255 || locked !== 1'b1) begin
      n_fail++; $display("FAIL err_saturate: err %0d locked %b expected 255 1", error_count, locked);
    end
  endtask

  task automatic test_reset_mid();
    slow_clk = ~slow_clk;
    repeat (LAT) tick();
    n_cmp++;
    if ((rise_pulse | fall_pulse) !== 1'b1 || period_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_pulse: pulse %b pv %b expected 1 1", rise_pulse | fall_pulse, period_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rise_pulse, fall_pulse, half_period, period_valid, locked, lost, error_count} !== 41'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0",
               {rise_pulse, fall_pulse, half_period, period_valid, locked, lost, error_count});
    end
    slow_clk = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_lost();
    test_error();
    test_timeout_edge();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Receive-side companion to the clock divider: samples a divided/slow clock in the fast `clock_in` domain and turns it into single-cycle rise/fall strobes for downstream logic. Measures each half-period in `clock_in` cycles and checks it against the expected divisor. Reports lock, loss-of-clock and a saturating error count. Sits between the divider output, or an external slow clock pin, and any logic that needs slow-rate enables instead of a second clock.

## Interface
- `EXPECTED_HALF`, default 28'd5: nominal half-period in `clock_in` cycles. Matches the divider's DIVISOR.
- `TOLERANCE`, default 28'd1: allowed ± deviation of a measured half-period.
- `LOCK_COUNT`, default 4: consecutive in-tolerance half-periods needed to lock. Range 1..15.
- `TIMEOUT`, default 28'd20: cycles without an edge before loss is declared. Must exceed `EXPECTED_HALF+TOLERANCE`.
- `clock_in` in 1: fast system clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `slow_clk` in 1: monitored clock, treated as data.
- `rise_pulse` out 1: one-cycle strobe per rising edge of `slow_clk`.
- `fall_pulse` out 1: one-cycle strobe per falling edge of `slow_clk`.
- `half_period` out 28: last measured edge-to-edge interval in `clock_in` cycles.
- `period_valid` out 1: one-cycle strobe when `half_period` updates.
- `locked` out 1: measurement stable within tolerance.
- `lost` out 1: no edge seen for `TIMEOUT` cycles.
- `error_count` out 8: out-of-tolerance events while locked. Saturates at 255.

## Operation
- Reset values: all outputs 0; FSM in IDLE; interval counter 0; history flop 0.
- Edge detection:
  - `slow_clk` goes through the synchronizer (see Configuration) into a history flop.
  - rise = sync & ~hist; fall = ~sync & hist. Both are registered into the pulse outputs.
  - Rise and fall are never asserted in the same cycle.
- Interval counter:
  - Cleared to 0 on the cycle an edge is detected.
  - Otherwise increments by 1, saturating at 2^28-1.
  - Measured interval = counter+1, so a divider toggling every 5 cycles measures 5.
- FSM states:
  - IDLE: wait for the first edge. That edge only starts the counter; no measurement, no `period_valid`. Go to ACQUIRE.
  - ACQUIRE: each edge produces a measurement.
    - In tolerance (|m-EXPECTED_HALF| ≤ TOLERANCE): increment the good-run counter.
    - Out of tolerance: clear the good-run counter.
    - When the run reaches `LOCK_COUNT`, go to LOCKED.
  - LOCKED: `locked`=1. An out-of-tolerance measurement increments `error_count` (saturating), clears the run and returns to ACQUIRE.
  - LOST: `lost`=1, `locked`=0. Entered from ACQUIRE or LOCKED when the counter reaches `TIMEOUT`-1 with no edge. The next edge goes to ACQUIRE with a fresh run, and this edge produces no measurement.
- Timeout boundary: if an edge and the timeout condition fall in the same cycle, the edge wins and the measurement is taken normally.
- Tolerance arithmetic: unsigned 28-bit compare written as m ≥ EXPECTED_HALF-TOLERANCE (clamped at 0) and m ≤ EXPECTED_HALF+TOLERANCE. No wrap-around.
- `lost` clears on the cycle the ACQUIRE transition registers.
- Reset asserted mid-operation: immediate return to reset values. `error_count` is not preserved.

## Timing
- With the synchronizer built in: `slow_clk` change first sampled at edge N → pulse high from edge N+3 for exactly one cycle.
- Without the synchronizer: pulse high from edge N+1.
- `half_period` and `period_valid` update on the same edge the pulse asserts.
- `locked` rises on the same edge as the `LOCK_COUNT`-th in-tolerance `period_valid`.
- `lost` rises `TIMEOUT` cycles after the last detected edge.
- Minimum resolvable half-period: 2 `clock_in` cycles. Faster inputs alias and the block gives no guarantee for them.

## Configuration
- `CLOCK_MONITOR_SYNC_EN` defined: two-flop synchronizer on `slow_clk` before the history flop. Use for an asynchronous or pin-sourced `slow_clk`.
- `CLOCK_MONITOR_SYNC_EN` not defined: `slow_clk` feeds the history flop directly. Legal only when `slow_clk` is a register in the `clock_in` domain (e.g. the divider output).
- Measured intervals are identical in both builds; only pulse latency changes.

## Structure
- Package `clock_monitor_pkg`: FSM state enum (IDLE, ACQUIRE, LOCKED, LOST), `CNT_W`=28, `ERR_W`=8.
- Sub-module `sync_edge_detect`: contains the synchronizer (macro-controlled), the history flop and the registered rise/fall pulses.
- The top level holds the counter, the comparator, the FSM and the error counter.

## Test plan
- Divider with DIVISOR=5 drives `slow_clk`, with the macro defined → `half_period`=5 on every `period_valid`; `locked`=1 after the 4th measurement; pulses alternate rise/fall every 5 cycles.
- Hold `slow_clk` static after lock → `lost`=1 exactly 20 cycles after the last edge, `locked`=0. Resume toggling → first edge produces no `period_valid`, and `locked` returns after 4 good measurements.
- While locked, inject one half-period of 8 cycles → `error_count` 0→1, FSM back to ACQUIRE, `locked`=0 on that edge.
- Edge arrives on the exact timeout cycle (interval 20) → measurement of 20 taken, `lost` stays 0, and the run is cleared because the value is out of tolerance.
- Force 300 errors → `error_count` holds at 255.
- Assert `reset_n`=0 mid-run, asynchronously → all outputs 0 immediately. Repeat the first scenario without the macro → pulse latency reduced by 2 cycles, `half_period` still 5.
